// File: rtl/cpu_debug_master.sv
// Board-level debug controller: run/pause/single-step CPU advance enable and a
// multiplexed hex seven-segment view of a selectable probe channel.
module cpu_debug_master #(
    parameter int unsigned DIV_COUNT   = 100_000_000,
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned WIN_N = DATA_W / (4 * DIGITS),
    localparam int unsigned WIN_W = (WIN_N > 1) ? $clog2(WIN_N) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pause,
    input  logic                     step_btn,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic [WIN_W-1:0]         win_sel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cpu_tick,
    output logic [31:0]              tick_count,
    output logic                     paused,
    output logic [6:0]               seg,
    output logic [DIGITS-1:0]        an
);

    localparam int unsigned DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_lvl_q, deb_lvl_d;
    logic              step_evt_q, step_evt_d;
    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpu_tick_q, cpu_tick_d;
    logic [31:0]       tick_count_q, tick_count_d;
    logic              paused_q, paused_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [DATA_W-1:0] word_c;
    logic [3:0]        nib_c;

    // Active-low {g,f,e,d,c,b,a} hex glyphs
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Step button: 2-FF synchronizer, stable-count debounce, rising-edge event
    always_comb begin
        sync1_d   = step_btn;
        sync2_d   = sync1_q;
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        step_evt_d = deb_lvl_d & ~deb_lvl_q;
    end

    // Run/pause/step sequencing; divider holds its value outside RUN
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cpu_tick_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (div_q == DIV_W'(DIV_COUNT - 1)) begin
                    div_d      = '0;
                    cpu_tick_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PAUSED: begin
                if (step_evt_q) begin
                    state_d    = ST_STEP;
                    cpu_tick_d = 1'b1;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = pause ? ST_PAUSED : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        tick_count_d = tick_count_q + 32'(cpu_tick_d);
        paused_d     = (state_d == ST_PAUSED);
    end

    // Digit scan counter, independent of the FSM
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Channel/window/digit nibble select; out-of-range selects show zero
    always_comb begin
        word_c = '0;
        nib_c  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_W'(k)) begin
                word_c = ch_data[k*DATA_W +: DATA_W];
            end
        end
        for (int w = 0; w < WIN_N; w++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (win_sel == WIN_W'(w) && idx_q == IDX_W'(d)) begin
                    nib_c = word_c[(w*DIGITS + d)*4 +: 4];
                end
            end
        end
        seg_d = hex7(nib_c);
        an_d  = '1;
        for (int d = 0; d < DIGITS; d++) begin
            an_d[d] = (idx_q != IDX_W'(d));
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            deb_lvl_q    <= 1'b0;
            step_evt_q   <= 1'b0;
            state_q      <= ST_RUN;
            div_q        <= '0;
            cpu_tick_q   <= 1'b0;
            tick_count_q <= '0;
            paused_q     <= 1'b0;
            ref_cnt_q    <= '0;
            idx_q        <= '0;
            seg_q        <= 7'h7F;
            an_q         <= '1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_lvl_q    <= deb_lvl_d;
            step_evt_q   <= step_evt_d;
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_tick_q   <= cpu_tick_d;
            tick_count_q <= tick_count_d;
            paused_q     <= paused_d;
            ref_cnt_q    <= ref_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign cpu_tick   = cpu_tick_q;
    assign tick_count = tick_count_q;
    assign paused     = paused_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule
